// File: rtl/wb_macro_fabric.sv
// rtl/wb_macro_fabric.sv - Wishbone fan-out to NUM_MACROS CIM macros with a CSR window and per-access ack timeout
module wb_macro_fabric #(
   parameter int          NUM_MACROS = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          WIN_BITS   = 12,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic [NUM_MACROS-1:0]   m_cyc_o,
   output logic [NUM_MACROS-1:0]   m_stb_o,
   output logic                    m_we_o,
   output logic [3:0]              m_sel_o,
   output logic [31:0]             m_dat_o,
   output logic [31:0]             m_adr_o,
   input  logic [NUM_MACROS-1:0]   m_ack_i,
   input  logic [32*NUM_MACROS-1:0] m_dat_i,
   output logic                    irq_o
);

   localparam int          IDX_W    = $clog2(NUM_MACROS + 1);
   localparam int          HI_LSB   = WIN_BITS + IDX_W;
   localparam logic [31:0] WIN_MASK = (32'd1 << WIN_BITS) - 32'd1;
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [31:0] ID_VAL   = {16'h5E1F, 8'(NUM_MACROS), 8'(TIMEOUT >> 8)};

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [NUM_MACROS-1:0]   stb_q, stb_d;
   logic [NUM_MACROS-1:0]   flag_q, flag_d;
   logic [15:0]             timer_q, timer_d;
   logic                    we_q, we_d;
   logic [3:0]              sel_q, sel_d;
   logic [31:0]             wdat_q, wdat_d;
   logic [31:0]             adr_q, adr_d;
   logic [31:0]             host_adr_q, host_adr_d;
   logic [31:0]             last_err_q, last_err_d;
   logic [31:0]             rdat_q, rdat_d;
   logic                    ack_q, ack_d;
   logic                    irq_q, irq_d;

   logic                    hit, is_macro, is_csr;
   logic [IDX_W-1:0]        req_idx;
   logic [NUM_MACROS-1:0]   req_oh;
   logic [31:0]             req_off, csr_rdata, sel_rdat;
   logic                    sel_ack;

   assign hit      = (wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
   assign req_idx  = wbs_adr_i[WIN_BITS +: IDX_W];
   assign is_macro = hit && (req_idx < IDX_W'(NUM_MACROS));
   assign is_csr   = hit && (req_idx == IDX_W'(NUM_MACROS));
   assign req_off  = wbs_adr_i & WIN_MASK;

   // The latched one-hot strobe doubles as the selected-port index for ack and data muxing
   always_comb begin
      req_oh   = '0;
      sel_rdat = '0;
      sel_ack  = 1'b0;
      for (int k = 0; k < NUM_MACROS; k++) begin
         req_oh[k] = (req_idx == IDX_W'(k));
         if (stb_q[k]) begin
            sel_rdat = m_dat_i[32*k +: 32];
            sel_ack  = m_ack_i[k];
         end
      end
   end

   always_comb begin
      case (req_off)
         32'h0:   csr_rdata = 32'(flag_q);
         32'h4:   csr_rdata = last_err_q;
         32'h8:   csr_rdata = ID_VAL;
         default: csr_rdata = 32'h0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      stb_d      = stb_q;
      flag_d     = flag_q;
      timer_d    = timer_q;
      we_d       = we_q;
      sel_d      = sel_q;
      wdat_d     = wdat_q;
      adr_d      = adr_q;
      host_adr_d = host_adr_q;
      last_err_d = last_err_q;
      rdat_d     = 32'h0;
      ack_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               we_d       = wbs_we_i;
               sel_d      = wbs_sel_i;
               wdat_d     = wbs_dat_i;
               adr_d      = req_off;
               host_adr_d = wbs_adr_i;
               if (is_macro) begin
                  stb_d   = req_oh;
                  timer_d = 16'h0;
                  state_d = S_ACCESS;
               end else begin
                  ack_d   = 1'b1;
                  state_d = S_RESP;
                  if (is_csr) begin
                     if (wbs_we_i) begin
                        if (req_off == 32'h0 && wbs_sel_i[0])
                           flag_d = flag_q & ~wbs_dat_i[NUM_MACROS-1:0];
                     end else begin
                        rdat_d = csr_rdata;
                     end
                  end
               end
            end
         end
         S_ACCESS: begin
            if (!wbs_cyc_i) begin
               stb_d   = '0;
               state_d = S_IDLE;
            end else if (sel_ack) begin
               stb_d   = '0;
               rdat_d  = we_q ? 32'h0 : sel_rdat;
               ack_d   = 1'b1;
               state_d = S_RESP;
            end else if (timer_q == TO_LAST) begin
               stb_d      = '0;
               flag_d     = flag_q | stb_q;
               last_err_d = host_adr_q;
               rdat_d     = ERR_DATA;
               ack_d      = 1'b1;
               state_d    = S_RESP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      irq_d = |flag_d;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= S_IDLE;
         stb_q      <= '0;
         flag_q     <= '0;
         timer_q    <= 16'h0;
         we_q       <= 1'b0;
         sel_q      <= 4'h0;
         wdat_q     <= 32'h0;
         adr_q      <= 32'h0;
         host_adr_q <= 32'h0;
         last_err_q <= 32'h0;
         rdat_q     <= 32'h0;
         ack_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         stb_q      <= stb_d;
         flag_q     <= flag_d;
         timer_q    <= timer_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         wdat_q     <= wdat_d;
         adr_q      <= adr_d;
         host_adr_q <= host_adr_d;
         last_err_q <= last_err_d;
         rdat_q     <= rdat_d;
         ack_q      <= ack_d;
         irq_q      <= irq_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdat_q;
   assign m_cyc_o   = stb_q;
   assign m_stb_o   = stb_q;
   assign m_we_o    = we_q;
   assign m_sel_o   = sel_q;
   assign m_dat_o   = wdat_q;
   assign m_adr_o   = adr_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_macro_fabric.sv
// tb/tb_wb_macro_fabric.sv - randomized bench for wb_macro_fabric against a transaction-level model
module tb_wb_macro_fabric;

   localparam int          NM   = 2;
   localparam int          TO   = 8;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]        sel = 4'h0;
   logic [31:0]       adr = 32'h0, dat = 32'h0;
   logic              ack_o;
   logic [31:0]       dat_o;
   logic [NM-1:0]     m_cyc, m_stb;
   logic              m_we;
   logic [3:0]        m_sel;
   logic [31:0]       m_dat_o, m_adr;
   logic [NM-1:0]     m_ack = '0;
   logic [32*NM-1:0]  m_dat_i = '0;
   logic              irq;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [NM-1:0]     mdl_flags = '0;
   logic [31:0]       mdl_last = 32'h0;
   logic [31:0]       got;

   always #5 clk = ~clk;

   wb_macro_fabric #(
      .NUM_MACROS(NM), .BASE_ADDR(BASE), .WIN_BITS(12), .TIMEOUT(TO), .ERR_DATA(ERR)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
      .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
      .m_dat_o(m_dat_o), .m_adr_o(m_adr), .m_ack_i(m_ack), .m_dat_i(m_dat_i),
      .irq_o(irq)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One host transaction; lat = cycles after strobe rise before the macro acks (>= TO means never)
   task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input int lat, output logic [31:0] rdata);
      int            win, kind, exp_n, got_n, stb_cnt, bad_stb, bad_cyc;
      logic [31:0]   exp_d, rd, off, b_adr, b_dat;
      logic [3:0]    b_sel;
      logic          b_we, got_irq, done;
      logic [NM-1:0] oh;
      win = -1; kind = 2; oh = '0;
      if (a >= BASE && a < BASE + 32'h4000) begin
         win  = int'((a - BASE) >> 12);
         kind = (win < NM) ? 0 : ((win == NM) ? 1 : 2);
      end
      off = a & 32'hFFF;
      rd  = $urandom;
      exp_d = 32'h0;
      if (kind == 0) begin
         oh[win] = 1'b1;
         if (lat < TO) begin
            exp_n = lat + 2;
            exp_d = w ? 32'h0 : rd;
         end else begin
            exp_n = TO + 1;
            exp_d = ERR;
            mdl_flags[win] = 1'b1;
            mdl_last = a;
         end
      end else begin
         exp_n = 1;
         if (kind == 1) begin
            if (w) begin
               if (off == 32'h0 && s[0]) mdl_flags = mdl_flags & ~d[NM-1:0];
            end else if (off == 32'h0) exp_d = 32'(mdl_flags);
            else if (off == 32'h4) exp_d = mdl_last;
            else if (off == 32'h8) exp_d = {16'h5E1F, 8'(NM), 8'(TO >> 8)};
         end
      end
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; m_ack = '0;
      for (int k = 0; k < NM; k++) m_dat_i[32*k +: 32] = $urandom;
      if (kind == 0) m_dat_i[32*win +: 32] = rd;
      got_n = 0; stb_cnt = 0; bad_stb = 0; bad_cyc = 0; done = 1'b0; rdata = 32'h0;
      got_irq = 1'b0; b_adr = 32'h0; b_dat = 32'h0; b_sel = 4'h0; b_we = 1'b0;
      for (int n = 1; n <= TO + 6 && !done; n++) begin
         @(negedge clk);
         if (m_cyc !== m_stb) bad_cyc++;
         if (m_stb != '0) begin
            if (kind == 0 && m_stb == oh) stb_cnt++;
            else bad_stb++;
         end
         if (n == 1) begin
            b_adr = m_adr; b_dat = m_dat_o; b_sel = m_sel; b_we = m_we;
         end
         if (ack_o) begin
            got_n = n; rdata = dat_o; got_irq = irq; done = 1'b1;
            cyc = 1'b0; stb = 1'b0; m_ack = '0;
         end else begin
            m_ack = NM'($urandom) & ~oh;
            if (kind == 0 && n == lat + 1) m_ack = m_ack | oh;
         end
      end
      if (!done) begin
         cyc = 1'b0; stb = 1'b0; m_ack = '0;
      end
      chk("ack_cycle", got_n, exp_n);
      chk("rdata", rdata, exp_d);
      chk("irq", {31'h0, got_irq}, {31'h0, |mdl_flags});
      chk("cyc_eq_stb", bad_cyc, 0);
      chk("stb_wrong_port", bad_stb, 0);
      if (kind == 0) begin
         chk("stb_cycles", stb_cnt, exp_n - 1);
         chk("m_adr", b_adr, off);
         chk("m_we", {31'h0, b_we}, {31'h0, w});
         chk("m_sel", {28'h0, b_sel}, {28'h0, s});
         if (w) chk("m_dat", b_dat, d);
      end
      @(negedge clk);
      chk("ack_one_cycle", {31'h0, ack_o}, 32'h0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ack"}, {31'h0, ack_o}, 32'h0);
      chk({tag, "_dat"}, dat_o, 32'h0);
      chk({tag, "_stb_cyc"}, {28'h0, m_stb, m_cyc}, 32'h0);
      chk({tag, "_bcast"}, m_adr | m_dat_o | {27'h0, m_we, m_sel}, 32'h0);
      chk({tag, "_irq"}, {31'h0, irq}, 32'h0);
   endtask

   task automatic do_abort();
      int acks, stb_seen;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h1000; sel = 4'hF; m_ack = '0;
      repeat (3) @(negedge clk);
      chk("abort_stb_pre", {30'h0, m_stb}, 32'h2);
      cyc = 1'b0; stb = 1'b0;
      acks = 0; stb_seen = 0;
      repeat (TO + 3) begin
         @(negedge clk);
         if (ack_o) acks++;
         if (m_stb != '0) stb_seen++;
      end
      chk("abort_no_ack", acks, 0);
      chk("abort_stb_drop", stb_seen, 0);
   endtask

   task automatic do_reset_mid_access();
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h1044; dat = 32'h0BAD_F00D; sel = 4'hF;
      repeat (2) @(negedge clk);
      chk("rst_stb_pre", {30'h0, m_stb}, 32'h2);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("rst_mid");
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat = 32'h0; sel = 4'h0;
      repeat (2) @(negedge clk);
      chk_outputs_zero("rst_hold");
      rst_n = 1'b1;
      mdl_flags = '0;
      mdl_last = 32'h0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      int          r, lat;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;

      do_access(32'h3000_1010, 1'b0, 32'h0, 4'hF, 3, got);
      do_access(32'h3000_0004, 1'b1, 32'hA5A5_0001, 4'hF, 2, got);
      do_access(32'h3000_1000, 1'b0, 32'h0, 4'hF, 1000, got);
      chk("timeout_data", got, 32'hDEAD_BEEF);
      do_access(32'h3000_2000, 1'b0, 32'h0, 4'hF, 0, got);
      chk("status_lit", got, 32'h2);
      do_access(32'h3000_2004, 1'b0, 32'h0, 4'hF, 0, got);
      chk("last_err_lit", got, 32'h3000_1000);
      do_access(32'h3000_2000, 1'b1, 32'h2, 4'hF, 0, got);
      chk("irq_cleared", {31'h0, irq}, 32'h0);
      do_access(32'h3000_0008, 1'b0, 32'h0, 4'hF, TO - 1, got);
      do_access(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, got);
      do_access(32'h3000_2008, 1'b0, 32'h0, 4'hF, 0, got);
      chk("id_lit", got, 32'h5E1F_0200);
      do_access(32'h3000_3000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, got);

      do_abort();
      do_access(32'h3000_2000, 1'b0, 32'h0, 4'hF, 0, got);

      do_access(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1000, got);
      do_reset_mid_access();
      do_access(32'h3000_2000, 1'b0, 32'h0, 4'hF, 0, got);
      do_access(32'h3000_2004, 1'b0, 32'h0, 4'hF, 0, got);

      for (int i = 0; i < 300; i++) begin
         r   = $urandom_range(0, 5);
         lat = $urandom_range(0, TO + 2);
         d   = $urandom;
         case (r)
            0, 1, 5: a = BASE + 32'($urandom_range(0, NM - 1)) * 32'h1000 + ($urandom & 32'hFFF);
            2: begin
               a = BASE + 32'h2000 + 32'($urandom_range(0, 3)) * 32'h4;
               if ($urandom_range(0, 3) == 0) a = BASE + 32'h2000 + ($urandom & 32'hFFC);
            end
            3: a = $urandom | 32'h8000_0000;
            default: a = BASE + 32'h3000 + ($urandom & 32'hFFF);
         endcase
         do_access(a, 1'($urandom), d, 4'($urandom), lat, got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
